rng_sample_buffer: RTL and testbench

- Parametrised capture buffer that sits downstream of the mt19937 generator (or any valid/ready random-number source).
- Records a programmed number of samples, or runs continuously in circular mode, into an internal synchronous RAM.
- Provides a 1-cycle-latency random-access readout port for checking and statistics.
- Replaces the fixed 10-word bench-driven RAM capture with a self-sequencing block.

---
 rtl/rng_sample_buffer.sv | 112 +++++++++++
 tb/tb_rng_sample_buffer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rng_sample_buffer.sv
// rtl/rng_sample_buffer.sv - self-sequencing capture RAM for a valid/ready random-number source
// One-shot or circular capture into synchronous RAM, with a 1-cycle random-access readout.
module rng_sample_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  circular,
  input  logic [ADDR_WIDTH:0]   count,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic                  wrapped
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, FINISH} state_t;

  state_t                state, state_next;
  logic                  circ_q;
  logic [ADDR_WIDTH:0]   target_q;
  logic [ADDR_WIDTH:0]   xfer_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  xfer;
  logic                  at_last;
  logic                  last_xfer;

  assign in_ready  = (state == CAPTURE);
  assign busy      = (state == CAPTURE);
  assign done      = (state == FINISH);
  assign xfer      = in_valid & in_ready;
  assign at_last   = (wr_ptr == LAST);
  // in_ready is decoded from state, so leaving CAPTURE on the count-th transfer stops further writes
  assign last_xfer = xfer && !circ_q && ((xfer_q + (ADDR_WIDTH+1)'(1)) == target_q);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (!circular && (count == '0)) ? FINISH : CAPTURE;
        end
      end
      CAPTURE: begin
        if (stop || last_xfer) begin
          state_next = FINISH;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      circ_q   <= 1'b0;
      target_q <= '0;
      xfer_q   <= '0;
      wr_ptr   <= '0;
      wrapped  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        circ_q   <= circular;
        target_q <= (count > DEPTH_W) ? DEPTH_W : count;
        xfer_q   <= '0;
        wr_ptr   <= '0;
        wrapped  <= 1'b0;
      end else if (xfer) begin
        wr_ptr <= at_last ? '0 : wr_ptr + ADDR_WIDTH'(1);
        xfer_q <= xfer_q + (ADDR_WIDTH+1)'(1);
        if (at_last && circ_q) begin
          wrapped <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Non-blocking write above makes a same-address read return the old word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= ({1'b0, rd_addr} < DEPTH_W) ? mem[rd_addr] : '0;
      end
    end
  end

endmodule

// File: tb/tb_rng_sample_buffer.sv
// tb/tb_rng_sample_buffer.sv - self-checking bench for rng_sample_buffer
// Two instances: DEPTH=256 for one-shot/random work, DEPTH=6 for non-power-of-two wrap.
module tb_rng_sample_buffer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] a_in_data, a_rd_data;
  logic        a_in_valid, a_in_ready, a_start, a_stop, a_circular;
  logic        a_rd_en, a_rd_valid, a_busy, a_done, a_wrapped;
  logic [8:0]  a_count;
  logic [7:0]  a_rd_addr, a_wr_ptr;

  logic [31:0] b_in_data, b_rd_data;
  logic        b_in_valid, b_in_ready, b_start, b_stop, b_circular;
  logic        b_rd_en, b_rd_valid, b_busy, b_done, b_wrapped;
  logic [3:0]  b_count;
  logic [2:0]  b_rd_addr, b_wr_ptr;

  rng_sample_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(256)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .start(a_start), .stop(a_stop), .circular(a_circular), .count(a_count),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
    .busy(a_busy), .done(a_done), .wr_ptr(a_wr_ptr), .wrapped(a_wrapped)
  );

  rng_sample_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .DEPTH(6)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .start(b_start), .stop(b_stop), .circular(b_circular), .count(b_count),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .busy(b_busy), .done(b_done), .wr_ptr(b_wr_ptr), .wrapped(b_wrapped)
  );

  int checks = 0;
  int errors = 0;

  // Reference contents: word k of a capture lands at address k mod DEPTH
  logic [31:0] ref_a [256];
  logic [31:0] ref_b [6];
  int          a_ptr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_read(input int addr, input logic [31:0] exp);
    a_rd_en   = 1'b1;
    a_rd_addr = addr[7:0];
    tick();
    a_rd_en = 1'b0;
    chk("a_rd_valid", {63'd0, a_rd_valid}, 64'd1);
    chk($sformatf("a_rd_data[%0d]", addr), {32'd0, a_rd_data}, {32'd0, exp});
  endtask

  task automatic b_read(input int addr, input logic [31:0] exp);
    b_rd_en   = 1'b1;
    b_rd_addr = addr[2:0];
    tick();
    b_rd_en = 1'b0;
    chk("b_rd_valid", {63'd0, b_rd_valid}, 64'd1);
    chk($sformatf("b_rd_data[%0d]", addr), {32'd0, b_rd_data}, {32'd0, exp});
  endtask

  // mode 0: valid always, data 100+k; mode 1: random valid/data plus ignored start pulses;
  // mode 2: valid pattern 1,0,0,1,1,0,1 then high
  task automatic a_oneshot(input int cnt, input int mode);
    int n, acc, cyc;
    int pat [7];
    pat = '{1, 0, 0, 1, 1, 0, 1};
    n = (cnt > 256) ? 256 : cnt;
    a_circular = 1'b0;
    a_count    = cnt[8:0];
    a_start    = 1'b1;
    tick();
    a_start = 1'b0;
    a_ptr   = 0;
    chk("a_busy_after_start", {63'd0, a_busy}, (n != 0) ? 64'd1 : 64'd0);
    acc = 0;
    cyc = 0;
    while (acc < n && cyc < 2000) begin
      case (mode)
        0: begin a_in_valid = 1'b1; a_in_data = 32'(100 + acc); end
        1: begin
          a_in_valid = 1'($urandom_range(0, 1));
          a_in_data  = $urandom;
          a_start    = ($urandom_range(0, 7) == 0);
        end
        default: begin
          a_in_valid = (cyc < 7) ? (pat[cyc] != 0) : 1'b1;
          a_in_data  = $urandom;
        end
      endcase
      chk("a_in_ready_capture", {63'd0, a_in_ready}, 64'd1);
      chk("a_wr_ptr_live", {56'd0, a_wr_ptr}, 64'(a_ptr));
      tick();
      if (a_in_valid) begin
        ref_a[a_ptr] = a_in_data;
        a_ptr = (a_ptr + 1) % 256;
        acc++;
      end
      cyc++;
    end
    chk("a_capture_bound", 64'(acc), 64'(n));
    a_in_valid = 1'b0;
    a_start    = 1'b0;
    chk("a_done_pulse", {63'd0, a_done}, 64'd1);
    chk("a_in_ready_finish", {63'd0, a_in_ready}, 64'd0);
    chk("a_busy_finish", {63'd0, a_busy}, 64'd0);
    chk("a_wr_ptr_final", {56'd0, a_wr_ptr}, 64'(a_ptr));
    chk("a_wrapped_oneshot", {63'd0, a_wrapped}, 64'd0);
    tick();
    chk("a_done_one_cycle", {63'd0, a_done}, 64'd0);
    chk("a_wr_ptr_hold", {56'd0, a_wr_ptr}, 64'(a_ptr));
  endtask

  initial begin
    int n, acc, cyc, addr;
    bit exp_wrap;
    logic [31:0] last;

    a_in_data = '0; a_in_valid = 0; a_start = 0; a_stop = 0; a_circular = 0;
    a_count = '0; a_rd_en = 0; a_rd_addr = '0;
    b_in_data = '0; b_in_valid = 0; b_start = 0; b_stop = 0; b_circular = 0;
    b_count = '0; b_rd_en = 0; b_rd_addr = '0;

    #3;
    chk("rst_in_ready", {63'd0, a_in_ready}, 64'd0);
    chk("rst_busy", {63'd0, a_busy}, 64'd0);
    chk("rst_done", {63'd0, a_done}, 64'd0);
    chk("rst_rd_valid", {63'd0, a_rd_valid}, 64'd0);
    chk("rst_wrapped", {63'd0, a_wrapped}, 64'd0);
    chk("rst_wr_ptr", {56'd0, a_wr_ptr}, 64'd0);
    chk("rst_rd_data", {32'd0, a_rd_data}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // one-shot count=10, data 100+k
    a_oneshot(10, 0);
    for (int k = 0; k < 10; k++) a_read(k, 32'(100 + k));
    tick();
    chk("a_rd_valid_drop", {63'd0, a_rd_valid}, 64'd0);
    chk("a_rd_data_hold", {32'd0, a_rd_data}, 64'd109);

    // count=0 one-shot: straight to done
    a_oneshot(0, 0);

    // backpressure
    a_oneshot(4, 2);
    for (int k = 0; k < 4; k++) a_read(k, ref_a[k]);

    // clamp: 300 requested, DEPTH written
    a_oneshot(300, 1);
    for (int k = 0; k < 16; k++) begin
      addr = $urandom_range(0, 255);
      a_read(addr, ref_a[addr]);
    end
    a_read(255, ref_a[255]);

    // random circular capture past DEPTH, stop coincident with the last transfer
    n = $urandom_range(260, 400);
    a_circular = 1'b1;
    a_count    = 9'($urandom);
    a_start    = 1'b1;
    tick();
    a_start  = 1'b0;
    a_ptr    = 0;
    exp_wrap = 0;
    acc = 0;
    cyc = 0;
    while (acc < n && cyc < 2000) begin
      a_in_valid = 1'($urandom_range(0, 1));
      a_in_data  = $urandom;
      if (acc == n - 1) begin
        a_in_valid = 1'b1;
        a_stop     = 1'b1;
      end
      chk("a_circ_busy", {63'd0, a_busy}, 64'd1);
      chk("a_circ_wrapped_live", {63'd0, a_wrapped}, {63'd0, exp_wrap});
      tick();
      if (a_in_valid) begin
        ref_a[a_ptr] = a_in_data;
        if (a_ptr == 255) exp_wrap = 1;
        a_ptr = (a_ptr + 1) % 256;
        acc++;
      end
      cyc++;
    end
    chk("a_circ_bound", 64'(acc), 64'(n));
    a_in_valid = 1'b0;
    a_stop     = 1'b0;
    chk("a_circ_done", {63'd0, a_done}, 64'd1);
    chk("a_circ_wrapped", {63'd0, a_wrapped}, 64'd1);
    chk("a_circ_wr_ptr", {56'd0, a_wr_ptr}, 64'(a_ptr));
    tick();
    chk("a_circ_done_drop", {63'd0, a_done}, 64'd0);
    a_read((a_ptr + 255) % 256, ref_a[(a_ptr + 255) % 256]);
    for (int k = 0; k < 8; k++) begin
      addr = $urandom_range(0, 255);
      a_read(addr, ref_a[addr]);
    end

    // same-cycle read/write at address 0 is read-first
    a_circular = 1'b0;
    a_count    = 9'd1;
    a_start    = 1'b1;
    tick();
    a_start = 1'b0; a_in_valid = 1'b1; a_in_data = 32'd5;
    tick();
    a_in_valid = 1'b0;
    ref_a[0] = 32'd5;
    tick();
    a_start = 1'b1;
    tick();
    a_start = 1'b0; a_in_valid = 1'b1; a_in_data = 32'hDEADBEEF;
    a_rd_en = 1'b1; a_rd_addr = 8'd0;
    tick();
    a_in_valid = 1'b0; a_rd_en = 1'b0;
    chk("a_rw_old_word", {32'd0, a_rd_data}, 64'd5);
    ref_a[0] = 32'hDEADBEEF;
    a_read(0, ref_a[0]);

    // reset mid-capture after 3 of 10 words
    a_count = 9'd10;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a_in_valid = 1'b1;
      a_in_data  = $urandom;
      a_rd_en    = 1'b1;
      a_rd_addr  = 8'd7;
      tick();
      ref_a[k] = a_in_data;
    end
    a_in_valid = 1'b0;
    a_rd_en    = 1'b0;
    chk("a_pre_reset_wr_ptr", {56'd0, a_wr_ptr}, 64'd3);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_busy", {63'd0, a_busy}, 64'd0);
    chk("arst_in_ready", {63'd0, a_in_ready}, 64'd0);
    chk("arst_wr_ptr", {56'd0, a_wr_ptr}, 64'd0);
    chk("arst_rd_valid", {63'd0, a_rd_valid}, 64'd0);
    chk("arst_rd_data", {32'd0, a_rd_data}, 64'd0);
    chk("arst_done", {63'd0, a_done}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("arst_no_done", {63'd0, a_done}, 64'd0);
    end
    a_oneshot(2, 1);
    a_read(0, ref_a[0]);
    a_read(1, ref_a[1]);
    a_read(2, ref_a[2]);

    // DEPTH=6 circular: 8 transfers of 1..8, then stop
    b_circular = 1'b1;
    b_start    = 1'b1;
    tick();
    b_start = 1'b0;
    for (int v = 1; v <= 8; v++) begin
      b_in_valid = 1'b1;
      b_in_data  = 32'(v);
      chk("b_busy", {63'd0, b_busy}, 64'd1);
      tick();
      ref_b[(v - 1) % 6] = 32'(v);
    end
    b_in_valid = 1'b0;
    chk("b_wr_ptr_before_stop", {61'd0, b_wr_ptr}, 64'd2);
    b_stop = 1'b1;
    tick();
    b_stop = 1'b0;
    chk("b_done", {63'd0, b_done}, 64'd1);
    chk("b_wrapped", {63'd0, b_wrapped}, 64'd1);
    chk("b_wr_ptr", {61'd0, b_wr_ptr}, 64'd2);
    chk("b_busy_finish", {63'd0, b_busy}, 64'd0);
    tick();
    chk("b_done_drop", {63'd0, b_done}, 64'd0);
    for (int k = 0; k < 6; k++) b_read(k, ref_b[k]);
    chk("b_ram_word0", {32'd0, ref_b[0]}, 64'd7);
    b_read(6, 32'd0);
    b_read(7, 32'd0);
    last = b_rd_data;
    tick();
    chk("b_rd_valid_drop", {63'd0, b_rd_valid}, 64'd0);
    chk("b_rd_data_hold", {32'd0, b_rd_data}, {32'd0, last});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
